// File: rtl/time_keeper_pkg.sv
// Shared definitions for the time-of-day clock: mode encodings, BCD limits
// and the single-step packed-BCD increment used by every field counter.
package time_keeper_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_SET_H = 2'b01,
        MODE_SET_M = 2'b10
    } mode_t;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;

    // Next packed-BCD value; wraps to 00 when the full byte equals max_v,
    // otherwise a units digit of 9 rolls to 0 and bumps the tens digit.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        logic [7:0] r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// One packed-BCD time field (seconds, minutes or hours) counting 00..MAX_BCD.
// wrap is the carry-out for the next field: high in the cycle this counter is
// about to roll from MAX_BCD to 00, and only when carrying is enabled.
module bcd_mod_counter
    import time_keeper_pkg::*;
#(
    parameter logic [7:0] MAX_BCD  = 8'h59,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       inc,
    input  logic       carry_en,
    output logic [7:0] value,
    output logic       wrap
);

    assign wrap = inc & carry_en & (value == MAX_BCD);

    // Field register: load takes priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= INIT_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= bcd_inc(value, MAX_BCD);
        end
    end

endmodule

// File: rtl/time_keeper.sv
// 24-hour HH:MM:SS time-of-day counter in packed BCD with a two-key manual
// set sequence (RUN -> SET_H -> SET_M -> RUN) and a once-per-day rollover pulse.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter logic [7:0] INIT_HH = 8'h12,
    parameter logic [7:0] INIT_MM = 8'h00,
    parameter logic [7:0] INIT_SS = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] mode,
    output logic       day_pulse
);

    mode_t state, state_nxt;
    logic  run, set_h, set_m;
    logic  field_inc;
    logic  sec_inc, min_inc, hour_inc;
    logic  sec_clr;
    logic  sec_wrap, min_wrap, hour_wrap;

    assign run   = (state == MODE_RUN);
    assign set_h = (state == MODE_SET_H);
    assign set_m = (state == MODE_SET_M);

    // A mode key in the same cycle as an increment key wins; the increment is dropped.
    assign field_inc = key_inc & ~key_mode;

    // Seconds only count while running; carries ripple only while running.
    assign sec_inc  = run & sec_tick;
    assign min_inc  = set_m ? field_inc : sec_wrap;
    assign hour_inc = set_h ? field_inc : min_wrap;

    // Leaving SET_M restarts the current minute from 00 seconds.
    assign sec_clr = set_m & key_mode;

    // Mode register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MODE_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next mode: each key_mode advances one step; the unused code falls back to RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            MODE_RUN:   if (key_mode) state_nxt = MODE_SET_H;
            MODE_SET_H: if (key_mode) state_nxt = MODE_SET_M;
            MODE_SET_M: if (key_mode) state_nxt = MODE_RUN;
            default:    state_nxt = MODE_RUN;
        endcase
    end

    bcd_mod_counter #(.MAX_BCD(BCD_59), .INIT_VAL(INIT_SS)) u_sec (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sec_clr),
        .load_val (8'h00),
        .inc      (sec_inc),
        .carry_en (run),
        .value    (sec_bcd),
        .wrap     (sec_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_59), .INIT_VAL(INIT_MM)) u_min (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val (8'h00),
        .inc      (min_inc),
        .carry_en (run),
        .value    (min_bcd),
        .wrap     (min_wrap)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_23), .INIT_VAL(INIT_HH)) u_hour (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .load_val (8'h00),
        .inc      (hour_inc),
        .carry_en (run),
        .value    (hour_bcd),
        .wrap     (hour_wrap)
    );

    // Rollover pulse: registered alongside the fields so it coincides with 00:00:00.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_pulse <= 1'b0;
        end else begin
            day_pulse <= hour_wrap;
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: reset, carry chains, midnight rollover,
// manual setting and simultaneous-input priority.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sec_tick = 1'b0, key_mode = 1'b0, key_inc = 1'b0;
    logic       tick2 = 1'b0, tick3 = 1'b0;
    logic       idle = 1'b0;

    logic [7:0] hh, mm, ss;
    logic [1:0] md;
    logic       dp;
    logic [7:0] hh2, mm2, ss2;
    logic [1:0] md2;
    logic       dp2;
    logic [7:0] hh3, mm3, ss3;
    logic [1:0] md3;
    logic       dp3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    time_keeper u_dut (
        .clk(clk), .rst_n(rst_n), .sec_tick(sec_tick), .key_mode(key_mode), .key_inc(key_inc),
        .hour_bcd(hh), .min_bcd(mm), .sec_bcd(ss), .mode(md), .day_pulse(dp)
    );

    time_keeper #(.INIT_HH(8'h23), .INIT_MM(8'h59), .INIT_SS(8'h58)) u_dut_eod (
        .clk(clk), .rst_n(rst_n), .sec_tick(tick2), .key_mode(idle), .key_inc(idle),
        .hour_bcd(hh2), .min_bcd(mm2), .sec_bcd(ss2), .mode(md2), .day_pulse(dp2)
    );

    time_keeper #(.INIT_HH(8'h09), .INIT_MM(8'h59), .INIT_SS(8'h59)) u_dut_carry (
        .clk(clk), .rst_n(rst_n), .sec_tick(tick3), .key_mode(idle), .key_inc(idle),
        .hour_bcd(hh3), .min_bcd(mm3), .sec_bcd(ss3), .mode(md3), .day_pulse(dp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s, input logic [23:0] exp);
        check({tag, " time"}, {8'h00, h, m, s}, {8'h00, exp});
    endtask

    // Hold the given inputs for n cycles, then return them low; leaves time at edge+1.
    task automatic drive(input logic t, input logic km, input logic ki, input int n);
        sec_tick = t;
        key_mode = km;
        key_inc  = ki;
        repeat (n) @(posedge clk);
        #1;
        sec_tick = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
    endtask

    task automatic tick_other(input bit second, input int n);
        if (second) tick2 = 1'b1; else tick3 = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick2 = 1'b0;
        tick3 = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset defaults
        apply_reset();
        check_time("reset", hh, mm, ss, 24'h120000);
        check("reset mode", {30'd0, md}, 32'd0);
        check("reset day_pulse", {31'd0, dp}, 32'd0);

        // Midnight rollover on the 23:59:58 instance
        check_time("eod init", hh2, mm2, ss2, 24'h235958);
        tick_other(1'b1, 1);
        check_time("eod 59", hh2, mm2, ss2, 24'h235959);
        check("eod day_pulse before", {31'd0, dp2}, 32'd0);
        tick_other(1'b1, 1);
        check_time("eod rollover", hh2, mm2, ss2, 24'h000000);
        check("eod day_pulse high", {31'd0, dp2}, 32'd1);
        @(posedge clk); #1;
        check("eod day_pulse one cycle", {31'd0, dp2}, 32'd0);
        check_time("eod hold", hh2, mm2, ss2, 24'h000000);

        // Full BCD carry chains on the 09:59:59 instance
        tick_other(1'b0, 1);
        check_time("carry 10:00:00", hh3, mm3, ss3, 24'h100000);
        check("carry day_pulse", {31'd0, dp3}, 32'd0);
        tick_other(1'b0, 1199);
        check_time("carry 10:19:59", hh3, mm3, ss3, 24'h101959);
        tick_other(1'b0, 1);
        check_time("carry 10:20:00", hh3, mm3, ss3, 24'h102000);

        // Counting, then asynchronous reset between edges
        drive(1'b1, 1'b0, 1'b0, 3);
        check_time("count 3", hh, mm, ss, 24'h120003);
        rst_n = 1'b0;
        #1;
        check_time("async reset", hh, mm, ss, 24'h120000);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // key_inc in RUN is ignored
        drive(1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b1, 1);
        check_time("run inc ignored", hh, mm, ss, 24'h120002);

        // Hour setting with wrap and frozen seconds
        drive(1'b0, 1'b1, 1'b0, 1);
        check("enter SET_H", {30'd0, md}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 10);
        check("set hour 22", {24'd0, hh}, 32'h22);
        drive(1'b0, 1'b0, 1'b1, 1);
        check("set hour 23", {24'd0, hh}, 32'h23);
        drive(1'b0, 1'b0, 1'b1, 1);
        check("set hour 00", {24'd0, hh}, 32'h00);
        check("set hour no day_pulse", {31'd0, dp}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1);
        check("set hour 01", {24'd0, hh}, 32'h01);
        drive(1'b1, 1'b0, 1'b0, 3);
        check_time("SET_H frozen", hh, mm, ss, 24'h010002);

        // Minute setting with wrap, then exit clears seconds
        drive(1'b0, 1'b1, 1'b0, 1);
        check("enter SET_M", {30'd0, md}, 32'd2);
        drive(1'b0, 1'b0, 1'b1, 59);
        check_time("set min 59", hh, mm, ss, 24'h015902);
        drive(1'b0, 1'b0, 1'b1, 1);
        check_time("set min wrap", hh, mm, ss, 24'h010002);
        check("set min no day_pulse", {31'd0, dp}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1);
        check("exit to RUN", {30'd0, md}, 32'd0);
        check_time("exit clears sec", hh, mm, ss, 24'h010000);
        drive(1'b1, 1'b0, 1'b0, 1);
        check_time("resume count", hh, mm, ss, 24'h010001);

        // Simultaneous mode and increment keys: only the mode changes
        drive(1'b0, 1'b1, 1'b1, 1);
        check("mode+inc RUN mode", {30'd0, md}, 32'd1);
        check_time("mode+inc RUN time", hh, mm, ss, 24'h010001);
        drive(1'b0, 1'b1, 1'b1, 1);
        check("mode+inc SET_H mode", {30'd0, md}, 32'd2);
        check_time("mode+inc SET_H time", hh, mm, ss, 24'h010001);

        // Reset discards setting; mode key together with a tick in RUN
        apply_reset();
        check("reset from SET_M", {30'd0, md}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 5);
        check_time("count 5", hh, mm, ss, 24'h120005);
        drive(1'b1, 1'b1, 1'b0, 1);
        check_time("mode+tick time", hh, mm, ss, 24'h120006);
        check("mode+tick mode", {30'd0, md}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
